// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one in-order I-cache read at a time,
// buffers {pc, instruction} responses in a circular FIFO for decode, and
// flushes/squashes on a branch-prediction redirect.
module fetch_unit #(
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned ADDRESS_SIZE     = 64,
    parameter int unsigned INSTRUCTION_SIZE = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDRESS_SIZE-1:0]       entry,
    input  logic                          redirect,
    input  logic [ADDRESS_SIZE-1:0]       redirect_pc,
    output logic                          icache_req,
    output logic [ADDRESS_SIZE-1:0]       icache_addr,
    input  logic                          icache_busy,
    input  logic                          icache_valid,
    input  logic [INSTRUCTION_SIZE-1:0]   icache_data,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [ADDRESS_SIZE-1:0]       deq_pc,
    output logic [INSTRUCTION_SIZE-1:0]   deq_instruction,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [ADDRESS_SIZE-1:0]       pc;
    logic [ADDRESS_SIZE-1:0]       icache_addr_latched;
    logic [PW-1:0]                 head;
    logic [PW-1:0]                 tail;
    logic [ADDRESS_SIZE-1:0]       mem_pc    [DEPTH];
    logic [INSTRUCTION_SIZE-1:0]   mem_instr [DEPTH];

    logic [CW:0] occupancy;
    logic        credit;
    logic        accept;
    logic        push;
    logic        pop;

    // Request/handshake qualifiers; a redirect blocks request, push and pop alike.
    always_comb begin
        occupancy   = {1'b0, count} + {{CW{1'b0}}, (state != S_FETCH)};
        credit      = occupancy < DEPTH_W;
        icache_req  = (state == S_FETCH) && credit && !redirect;
        icache_addr = pc;
        accept      = icache_req && !icache_busy;
        push        = (state == S_WAIT) && icache_valid && !redirect;
        deq_valid   = (count != '0);
        pop         = deq_valid && deq_ready && !redirect;
    end

    // FIFO head is shown only when valid so the outputs read zero when empty.
    always_comb begin
        deq_pc          = '0;
        deq_instruction = '0;
        if (deq_valid) begin
            deq_pc          = mem_pc[head];
            deq_instruction = mem_instr[head];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: redirect squashes an outstanding read unless its response lands in the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (icache_valid) begin
                    state_next = S_FETCH;
                end else if (redirect) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (icache_valid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Program counter and the address of the outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                  <= entry;
            icache_addr_latched <= '0;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (accept) begin
            pc                  <= pc + ADDRESS_SIZE'(4);
            icache_addr_latched <= pc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]    <= icache_addr_latched;
            mem_instr[tail] <= icache_data;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage that owns the program counter and issues in-order instruction reads to the I-cache. It buffers each returned `{pc, instruction}` pair in a small FIFO and hands pairs to branch prediction/decode with a valid/ready handshake. On a branch-prediction redirect it flushes the FIFO, squashes any in-flight read and restarts from the redirect target. This decouples cache latency from the front-end stall signal.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `ADDRESS_SIZE`, 64 — PC width.
- `INSTRUCTION_SIZE`, 32 — instruction width.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `entry` in ADDRESS_SIZE — program entry point; held static while `reset` is high.
- `redirect` in 1 — overwrite PC (from branch predictor).
- `redirect_pc` in ADDRESS_SIZE — new fetch target.
- `icache_req` out 1 — read request.
- `icache_addr` out ADDRESS_SIZE — read address (= `pc`).
- `icache_busy` in 1 — cache cannot accept a request this cycle.
- `icache_valid` in 1 — response strobe for the outstanding read.
- `icache_data` in INSTRUCTION_SIZE — response instruction.
- `deq_valid` out 1 — FIFO head valid.
- `deq_ready` in 1 — consumer takes head (i.e. `!frontend_stall`).
- `deq_pc` out ADDRESS_SIZE — head PC.
- `deq_instruction` out INSTRUCTION_SIZE — head instruction.
- `count` out $clog2(DEPTH)+1 — occupied entries.

## Operation
- State machine has three states:
  - FETCH: no read outstanding.
  - WAIT: read outstanding, result kept.
  - DROP: read outstanding, result discarded.
- `credit` = (`count` + (state≠FETCH)) < DEPTH.
- `icache_req` = (state==FETCH) && `credit` && !`redirect`. It is combinational; `icache_addr` = `pc`.
- FETCH:
  - Request accepted when `icache_req` && !`icache_busy`.
  - On acceptance, state goes to WAIT and `pc` ← `pc`+4. Addition is modulo 2^ADDRESS_SIZE.
- WAIT:
  - On `icache_valid`, push {`icache_addr_latched`, `icache_data`} and go to FETCH.
  - The request address is latched at acceptance.
- DROP:
  - On `icache_valid`, discard the data and go to FETCH.
- `icache_valid` in the FETCH state is ignored.
- Redirect (highest priority, any state):
  - `pc` ← `redirect_pc`.
  - FIFO is emptied: head=tail=0, `count`=0.
  - If state is WAIT, go to DROP; DROP stays DROP.
  - If state is FETCH, stay FETCH, with no request issued that cycle.
  - A response arriving in the redirect cycle is discarded. If state was WAIT/DROP, the next state is FETCH.
  - `deq_ready` in the redirect cycle has no effect.
- FIFO:
  - Circular buffer with head/tail pointers of width $clog2(DEPTH), wrapping DEPTH-1→0.
  - Push writes at tail; pop (`deq_valid`&&`deq_ready`) advances head.
  - Simultaneous push and pop leaves `count` unchanged; valid both when empty-at-start is impossible (push is visible next cycle).
  - Overflow cannot occur because of `credit`; popping when empty is ignored.
- `deq_valid` = `count`≠0. `deq_pc`/`deq_instruction` are read combinationally from the head.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge):
  - `pc` = `entry`, state = FETCH, `count` = 0, head = tail = 0.
  - `icache_req` = 1 once `reset` drops, given `icache_busy` = 0.
  - `deq_valid` = 0 and `deq_*` = 0.
- Reset asserted mid-operation immediately clears all state. A later stale `icache_valid` is ignored because the state is FETCH.
- Latency:
  - Response edge → `deq_valid` high at the next cycle.
  - Minimum request-to-dequeue is 2 cycles for a 1-cycle cache.
- Throughput is one instruction per (cache latency + 1) cycles; only one read is outstanding at a time.
- Redirect edge: the new `pc` is requested in the following cycle if the state is FETCH. From DROP, the request follows the cycle after the squashed response.
- At full occupancy, `icache_req` is deasserted. When a pop occurs in cycle N, `icache_req` rises in cycle N+1.

## Test plan
- Reset with `entry`=0x1000, 1-cycle cache returning data = address: `icache_addr` sequence is 0x1000, 0x1004, 0x1008, …; `deq_pc`/`deq_instruction` pairs match; first `deq_valid` occurs 2 cycles after reset release.
- Hold `deq_ready`=0, DEPTH=8: exactly 8 entries fill, `count`=8, `icache_req` stays 0. One pop restores `icache_req` the next cycle; `count` returns to 8.
- Redirect to 0x2000 while WAIT with 3 entries queued: `count`→0, `deq_valid`→0. The returning response is dropped. The next `icache_addr` is 0x2000, and the first dequeued pc is 0x2000.
- Redirect coincident with `icache_valid` and `deq_ready`: nothing is pushed or popped, `count`=0, the next request goes to `redirect_pc`.
- `icache_busy` held high for 5 cycles in FETCH: `icache_req` is held with a stable address and `pc` is not incremented; acceptance happens on the first non-busy cycle.
- Assert reset asynchronously mid-WAIT with 4 entries queued: outputs clear without a clock edge. A post-reset stray `icache_valid` is ignored; fetch restarts at `entry`.
